// File: rtl/sync_ncl_tx.sv
// Clocked-to-NCL boundary transmitter: single-rail valid/ready words in, flop-driven dual-rail DATA/NULL wavefronts out.
// Latency: from IDLE with ko_s=1, a word accepted at edge k is on the rails after edge k+1; ko edges take SYNC_STAGES+1 edges to act.
// Backpressure: in_ready is !full of the one-word holding register, which is freed only when a DATA wavefront returns to NULL.
module sync_ncl_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ko,
    output logic [WIDTH-1:0] out_t,
    output logic [WIDTH-1:0] out_f,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_IDLE = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_N-1:0] ko_sync;
    logic              ko_s;
    logic [WIDTH-1:0]  hold_dat;
    logic              full;
    logic              accept;
    logic              load_data;
    logic              drop_data;
    logic              wd_run;
    logic [WD_W-1:0]   wd_cnt;

    // ko is fully asynchronous; nothing but the synchronized copy is ever looked at
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ko_sync <= '0;
        end else begin
            ko_sync <= {ko_sync[SYNC_N-2:0], ko};
        end
    end

    assign ko_s     = ko_sync[SYNC_N-1];
    assign in_ready = !full;
    assign accept   = in_valid && !full;
    assign busy     = (state_q != S_IDLE) || full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_data = 1'b0;
        drop_data = 1'b0;
        case (state_q)
            S_NULL: begin
                if (ko_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (full && ko_s) begin
                    state_d   = S_DATA;
                    load_data = 1'b1;
                end
            end
            S_DATA: begin
                if (!ko_s) begin
                    state_d   = S_NULL;
                    drop_data = 1'b1;
                end
            end
            default: begin
                state_d = S_NULL;
            end
        endcase
    end

    // full is always set while in DATA, so accept and drop_data never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_dat <= '0;
            full     <= 1'b0;
        end else if (accept) begin
            hold_dat <= in_data;
            full     <= 1'b1;
        end else if (drop_data) begin
            full     <= 1'b0;
        end
    end

    // Rails come straight from flops and every pair switches on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_t <= '0;
            out_f <= '0;
        end else if (load_data) begin
            out_t <= hold_dat;
            out_f <= ~hold_dat;
        end else if (drop_data) begin
            out_t <= '0;
            out_f <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (drop_data) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    // Watchdog only observes; a stuck downstream leaves the FSM waiting with err raised
    assign wd_run = ((state_q == S_DATA) && ko_s) || ((state_q == S_NULL) && !ko_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else if (state_d != state_q) begin
            wd_cnt <= '0;
        end else if (wd_run) begin
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if ((TIMEOUT > 0) && (wd_cnt == WD_LAST)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_ncl_tx.sv
// Directed bench for sync_ncl_tx (WIDTH=8, SYNC_STAGES=2, TIMEOUT=16, CNT_W=4) with a ko-driving downstream model.
module tb_sync_ncl_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ko;
    logic [7:0] out_t;
    logic [7:0] out_f;
    logic       busy;
    logic       err;
    logic [3:0] xfer_cnt;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_illegal = 0;
    int n_partial = 0;

    sync_ncl_tx #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .TIMEOUT    (16),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ko      (ko),
        .out_t   (out_t),
        .out_f   (out_f),
        .busy    (busy),
        .err     (err),
        .xfer_cnt(xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rails must always be all-NULL or a complete DATA codeword
    always @(negedge clk) begin
        if ((out_t & out_f) != 8'h00) n_illegal++;
        if (((out_t | out_f) != 8'h00) && ((out_t | out_f) != 8'hFF)) n_partial++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    // Send one word from IDLE and play downstream: drop ko on DATA, raise it on NULL
    task automatic do_xfer(input logic [7:0] w);
        logic [7:0] wn;
        wn = ~w;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50 && ((out_t | out_f) != 8'hFF); i++) @(negedge clk);
        chk("xfer_t", out_t, w);
        chk("xfer_f", out_f, wn);
        ko = 1'b0;
        for (int i = 0; i < 50 && ((out_t | out_f) != 8'h00); i++) @(negedge clk);
        chk("xfer_null", out_t | out_f, 0);
        ko = 1'b1;
        wait_idle("xfer_idle");
    endtask

    initial begin
        rst      = 1'b0;
        ko       = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_t", out_t, 0);
        chk("rst_f", out_f, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_busy", busy, 1);
        chk("rst_err", err, 0);
        chk("rst_cnt", xfer_cnt, 0);
        rst = 1'b1;

        // Test 1: NULL->IDLE after SYNC_STAGES+1 edges, then single word latency
        repeat (2) @(negedge clk);
        chk("t1_not_idle", busy, 1);
        @(negedge clk);
        chk("t1_idle", busy, 0);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t1_k_t", out_t, 0);
        chk("t1_k_rdy", in_ready, 0);
        @(negedge clk);
        chk("t1_k1_t", out_t, 8'hA5);
        chk("t1_k1_f", out_f, 8'h5A);
        ko = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_hold_t", out_t, 8'hA5);
        @(negedge clk);
        chk("t1_null_t", out_t, 0);
        chk("t1_null_f", out_f, 0);
        chk("t1_cnt", xfer_cnt, 1);
        chk("t1_rdy", in_ready, 1);
        ko = 1'b1;
        wait_idle("t1_back_idle");

        // Test 2: stream of three words; counter is cumulative (1 + 3)
        do_xfer(8'h01);
        do_xfer(8'h02);
        do_xfer(8'h03);
        chk("t2_cnt", xfer_cnt, 4);

        // Test 3: ko held high in DATA, watchdog fires 16 edges after entry
        @(negedge clk);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("t3_err_early", err, 0);
        chk("t3_rail15", out_t, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_rail16", out_t, 8'h3C);
        chk("t3_rail16_f", out_f, 8'hC3);

        // Test 4: glitch between edges is invisible; one straddling an edge gives a clean exit
        #1 ko = 1'b0;
        #2 ko = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_glitch_t", out_t, 8'h3C);
        chk("t4_glitch_cnt", xfer_cnt, 4);
        ko = 1'b0;
        @(posedge clk);
        #2 ko = 1'b1;
        for (int i = 0; i < 20 && ((out_t | out_f) != 8'h00); i++) @(negedge clk);
        chk("t4_exit_null", out_t | out_f, 0);
        chk("t4_exit_cnt", xfer_cnt, 5);
        wait_idle("t4_idle");
        chk("t4_err_sticky", err, 1);

        // Test 5: asynchronous reset in the middle of DATA
        @(negedge clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 20 && (out_t != 8'hFF); i++) @(negedge clk);
        chk("t5_data", out_t, 8'hFF);
        #2 rst = 1'b0;
        #1;
        chk("t5_t", out_t, 0);
        chk("t5_f", out_f, 0);
        chk("t5_rdy", in_ready, 1);
        chk("t5_cnt", xfer_cnt, 0);
        chk("t5_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_idle("t5_idle");

        // Test 6: 17 transfers wrap a 4-bit counter to 1
        for (int n = 0; n < 17; n++) begin
            do_xfer(8'(n * 37 + 11));
        end
        chk("t6_cnt", xfer_cnt, 1);
        chk("t6_err", err, 0);

        chk("illegal_pair", n_illegal, 0);
        chk("partial_rail", n_partial, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/sync_ncl_tx.md
Name: sync_ncl_tx

Overview:
- Clocked-to-NCL boundary transmitter. Sits directly upstream of the dual-rail threshold-gate pipeline and feeds its first register stage.
- Accepts single-rail words over a valid/ready handshake.
- Emits dual-rail DATA/NULL wavefronts, sequenced by the downstream completion signal ko.
- Outputs are flop-driven, so the NCL logic never sees glitches or illegal codewords.

Parameters:
- WIDTH, 8: data bits; produces WIDTH dual-rail pairs.
- SYNC_STAGES, 2: flops in the ko synchronizer, minimum 2.
- TIMEOUT, 1024: cycles one phase may wait for ko before err is set; 0 disables the watchdog.
- CNT_W, 16: width of the transfer counter.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous, active-low.
- in_data, in, WIDTH: single-rail word.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: holding register is empty; a word is accepted on clk edge when in_valid & in_ready.
- ko, in, 1: async completion from downstream; 1 = request-for-data, 0 = request-for-null.
- out_t, out, WIDTH: true rails.
- out_f, out, WIDTH: false rails.
- busy, out, 1: high when state is not IDLE or the holding register is full.
- err, out, 1: sticky watchdog timeout flag.
- xfer_cnt, out, CNT_W: count of completed DATA wavefronts.

Behaviour:
- Reset (rst=0, async):
  - state=NULL; holding register empty; in_ready=1.
  - out_t=out_f=0 (NULL); all sync flops=0; err=0; xfer_cnt=0; watchdog=0.
- ko_s is ko after SYNC_STAGES flops. All decisions use ko_s only.
- Holding register:
  - Loads in_data on accept; full flag set the same edge.
  - Cleared on the DATA->NULL transition.
  - in_ready = !full, a registered-state function with no combinational path from in_valid.
- FSM:
  - NULL: drive out_t=out_f=0. If ko_s=1, go to IDLE next edge.
  - IDLE: drive NULL. If full=1 and ko_s=1, go to DATA. On that same edge out_t<=reg and out_f<=~reg.
  - DATA: hold rails. If ko_s=0, go to NULL. On that same edge out_t=out_f<=0, full<=0, xfer_cnt<=xfer_cnt+1 (wraps modulo 2^CNT_W).
- Rail rules:
  - out_t[i]&out_f[i] is never 1.
  - Rails change only on DATA entry or DATA exit.
  - Every pair goes NULL->DATA or DATA->NULL together in one edge.
- Latency:
  - With state=IDLE and ko_s=1, a word accepted at edge k appears on the rails after edge k+1.
  - ko edge to FSM reaction: SYNC_STAGES edges to update ko_s, then the transition on the following edge.
- Prefetch: in NULL or IDLE with full=0, a new word may be accepted. Acceptance in the same edge as DATA->NULL is not possible, because in_ready is still 0 that cycle.
- Simultaneous events: in IDLE, an accept and ko_s=1 in the same edge make full=1 only. The DATA transition happens on the next edge.
- Watchdog:
  - Counter increments each edge while in DATA or NULL with the exit condition false.
  - Clears on any state change.
  - When the counter reaches TIMEOUT (TIMEOUT>0), err<=1. err stays set until reset.
  - The FSM keeps waiting; a timeout never forces a transition.
- Reset mid-DATA: rails drop to NULL asynchronously and the held word is discarded. Downstream recovers through its own NULL cycle.
- busy=0 only in IDLE with full=0.

Test Plan:
1. Reset, ko=1, in_data=0xA5 with in_valid=1 for one cycle.
   - Required: after SYNC_STAGES+1 edges, state=IDLE.
   - Accept edge k; after edge k+1, out_t=0xA5 and out_f=0x5A.
   - Drop ko to 0: rails go 0/0 SYNC_STAGES+1 edges later; xfer_cnt=1; in_ready=1.
2. Back-to-back stream 0x01,0x02,0x03 with a ko-toggling downstream model.
   - Required: three DATA wavefronts carrying exactly those values in order, each separated by NULL; xfer_cnt=3.
   - No cycle has out_t&out_f nonzero.
3. Hold ko=1 throughout, send one word.
   - Required: rails stay at that DATA value.
   - TIMEOUT=16: err=1 exactly 16 edges after DATA entry, with no rail change.
4. ko pulse shorter than one clk while in DATA.
   - Required: either no transition, or a single clean DATA->NULL; never a partial-rail change.
5. Assert rst low mid-DATA (out_t=0xFF).
   - Required: out_t=out_f=0 immediately, without waiting for clk; in_ready=1; xfer_cnt=0; err=0.
6. Set CNT_W=4 and run 17 transfers.
   - Required: xfer_cnt=1 (wraps at 16).
